// File: rtl/uart_pkg.sv
// Shared register map, bit positions and reset values for the UART receive controller.
package uart_pkg;

  // Word addresses on the Wishbone port
  localparam logic [1:0] ADDR_RXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  // STATUS bit positions; count field starts at ST_COUNT_LSB
  localparam int unsigned ST_NONEMPTY  = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_BUSY      = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

  // CTRL bit positions
  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_FLUSH  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  // CTRL after reset: receiver enabled, interrupt masked
  localparam logic [2:0] CTRL_RESET = 3'h1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush; a pop frees the slot for a same-cycle push when full.
module uart_sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [WIDTH-1:0]      i_din,
  output logic [WIDTH-1:0]      o_dout,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_count = count_q;
  assign o_dout  = mem_q[rd_ptr_q];

  // Pop first, so a full FIFO can still accept a byte in the same cycle as a read
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  // Pointer and occupancy next-state; flush empties the FIFO and overrides everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because occupancy gates every read
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Wishbone-facing receive controller: byte capture FIFO, overrun tracking and interrupt.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned WB_DATA_WIDTH   = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_BITS-1:0]     i_rx_data,
  input  logic                     i_rx_data_ready,
  input  logic                     i_rx_busy,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [1:0]               i_wb_addr,
  input  logic [WB_DATA_WIDTH-1:0] i_wb_data,
  output logic                     o_wb_ack,
  output logic                     o_wb_stall,
  output logic [WB_DATA_WIDTH-1:0] o_wb_data,
  output logic                     o_irq
);

  localparam int unsigned CW = FIFO_DEPTH_LOG2 + 1;

  logic                     ack_q, ack_d;
  logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                     irq_q, irq_d;
  logic                     overrun_q, overrun_d;
  logic                     enable_q, enable_d;
  logic                     irq_en_q, irq_en_d;

  logic                     req, rd_req, wr_req;
  logic                     fifo_push, fifo_pop, fifo_flush;
  logic [DATA_BITS-1:0]     fifo_dout;
  logic                     fifo_full, fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic                     overrun_set, overrun_clr;
  logic [WB_DATA_WIDTH-1:0] status_word, rd_mux;
  logic                     unused_wdata;

  assign req    = i_wb_cyc & i_wb_stb;
  assign rd_req = req & ~i_wb_we;
  assign wr_req = req &  i_wb_we;

  assign o_wb_stall   = 1'b0;
  assign o_wb_ack     = ack_q;
  assign o_wb_data    = rdata_q;
  assign o_irq        = irq_q;
  assign unused_wdata = ^i_wb_data[WB_DATA_WIDTH-1:3];

  // FIFO control: reading RXDATA pops, CTRL flush bit empties, disabled receiver drops bytes
  assign fifo_pop    = rd_req & (i_wb_addr == ADDR_RXDATA);
  assign fifo_flush  = wr_req & (i_wb_addr == ADDR_CTRL) & i_wb_data[CTRL_FLUSH];
  assign fifo_push   = i_rx_data_ready & enable_q & ~fifo_flush;
  assign overrun_set = fifo_push & fifo_full & ~(fifo_pop & ~fifo_empty);
  assign overrun_clr = wr_req & (i_wb_addr == ADDR_STATUS) & i_wb_data[ST_OVERRUN];

  uart_sync_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .i_flush (fifo_flush),
    .i_din   (i_rx_data),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // STATUS word assembled from pre-update state
  always_comb begin
    status_word                         = '0;
    status_word[ST_NONEMPTY]            = ~fifo_empty;
    status_word[ST_FULL]                = fifo_full;
    status_word[ST_OVERRUN]             = overrun_q;
    status_word[ST_BUSY]                = i_rx_busy;
    status_word[ST_COUNT_LSB +: CW]     = fifo_count;
  end

  // Read mux; empty RXDATA and the reserved slot read as zero
  always_comb begin
    rd_mux = '0;
    case (i_wb_addr)
      ADDR_RXDATA: if (!fifo_empty) rd_mux = WB_DATA_WIDTH'(fifo_dout);
      ADDR_STATUS: rd_mux = status_word;
      ADDR_CTRL: begin
        rd_mux[CTRL_ENABLE] = enable_q;
        rd_mux[CTRL_IRQ_EN] = irq_en_q;
      end
      default: rd_mux = '0;
    endcase
  end

  // Next-state for bus response, control bits, sticky overrun and interrupt
  always_comb begin
    ack_d     = req;
    rdata_d   = rd_req ? rd_mux : '0;
    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    overrun_d = overrun_q;
    if (wr_req && (i_wb_addr == ADDR_CTRL)) begin
      enable_d = i_wb_data[CTRL_ENABLE];
      irq_en_d = i_wb_data[CTRL_IRQ_EN];
    end
    if (overrun_set)      overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
    irq_d = irq_en_q & (~fifo_empty | overrun_q);
  end

  // Controller registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
      enable_q  <= CTRL_RESET[CTRL_ENABLE];
      irq_en_q  <= CTRL_RESET[CTRL_IRQ_EN];
    end else begin
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
      enable_q  <= enable_d;
      irq_en_q  <= irq_en_d;
    end
  end

endmodule
